// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared types and constants for the spi_rx_stream receiver.
//   rx_state_e  - receiver FSM states
//   DROP_CNT_W  - width of the saturating drop counter
//   level_width - width of a FIFO level/pointer for a given depth
package spi_rx_pkg;

    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PUSH,
        ABORT
    } rx_state_e;

    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock word FIFO with extra-MSB wrap pointers.
//   clk, rst     - clock, synchronous active-high reset
//   push, wdata  - write request and data (accepted when not full or popping)
//   pop          - read request (ignored when empty)
//   rdata        - head entry, combinational from storage
//   full, empty  - status flags
//   level        - number of entries held
module sync_fifo
    import spi_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                wdata,
    input  logic                            pop,
    output logic [WIDTH-1:0]                rdata,
    output logic                            full,
    output logic                            empty,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign level = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the head slot, so a push at full still fits.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spi_rx_stream.sv
// spi_rx_stream: oversampled multi-lane serial receiver with word FIFO.
//   aclk, areset - system clock, synchronous active-high reset
//   sclk, svalid - async serial bit clock and frame enable (synchronised)
//   sdata        - LANES serial data bits, captured on sclk rising edge
//   fifo_data/fifo_valid/fifo_ready - output word stream
//   fifo_level   - words currently buffered
//   frame_err    - one-cycle pulse when a partial word is discarded
//   drop_count   - saturating count of words lost to a full FIFO
module spi_rx_stream
    import spi_rx_pkg::*;
#(
    parameter int unsigned PACKET_LENGTH = 32,
    parameter int unsigned LANES         = 1,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MSB_FIRST     = 1,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 sclk,
    input  logic [LANES-1:0]                     sdata,
    input  logic                                 svalid,
    output logic [PACKET_LENGTH-1:0]             fifo_data,
    output logic                                 fifo_valid,
    input  logic                                 fifo_ready,
    output logic [level_width(FIFO_DEPTH)-1:0]   fifo_level,
    output logic                                 frame_err,
    output logic [DROP_CNT_W-1:0]                drop_count
);

    localparam int unsigned CNT_W = $clog2(PACKET_LENGTH + 1);
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
    localparam logic [CNT_W-1:0] PL_C    = CNT_W'(PACKET_LENGTH);

    // Input synchronisers; the last stage is the usable sampled value.
    logic [SYNC_STAGES-1:0]            sclk_sync_q;
    logic [SYNC_STAGES-1:0]            svalid_sync_q;
    logic [SYNC_STAGES-1:0][LANES-1:0] sdata_sync_q;
    logic                              sclk_s_d_q;
    logic                              sclk_s, svalid_s, beat;
    logic [LANES-1:0]                  sdata_s;

    rx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [PACKET_LENGTH-1:0]  shift_q, shift_d;
    logic [DROP_CNT_W-1:0]     drop_q, drop_d;
    logic                      push, fifo_full, fifo_empty, fifo_pop;

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign svalid_s = svalid_sync_q[SYNC_STAGES-1];
    assign sdata_s  = sdata_sync_q[SYNC_STAGES-1];
    assign beat     = sclk_s & ~sclk_s_d_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            sclk_sync_q   <= '0;
            svalid_sync_q <= '0;
            sdata_sync_q  <= '0;
            sclk_s_d_q    <= 1'b0;
        end else begin
            sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            svalid_sync_q <= {svalid_sync_q[SYNC_STAGES-2:0], svalid};
            sdata_sync_q  <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            sclk_s_d_q    <= sclk_s;
        end
    end

    assign fifo_valid = ~fifo_empty;
    assign fifo_pop   = fifo_valid & fifo_ready;
    assign drop_count = drop_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        drop_d    = drop_q;
        push      = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (svalid_s) state_d = RECV;
            end
            RECV: begin
                if (beat && svalid_s) begin
                    if (MSB_FIRST != 0)
                        shift_d = {shift_q[PACKET_LENGTH-LANES-1:0], sdata_s};
                    else
                        shift_d = {sdata_s, shift_q[PACKET_LENGTH-1:LANES]};
                    count_d = count_q + LANES_C;
                    if (count_d == PL_C) state_d = PUSH;
                end else if (!svalid_s) begin
                    state_d = (count_q != '0) ? ABORT : IDLE;
                end
            end
            PUSH: begin
                push    = 1'b1;
                count_d = '0;
                if (fifo_full && !fifo_pop && (drop_q != '1)) drop_d = drop_q + 1'b1;
                state_d = svalid_s ? RECV : IDLE;
            end
            ABORT: begin
                frame_err = 1'b1;
                count_d   = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (PACKET_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (push),
        .wdata (shift_q),
        .pop   (fifo_pop),
        .rdata (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_spi_rx_stream.sv
// tb_spi_rx_stream: randomized self-checking bench for spi_rx_stream.
// Two instances: single-lane MSB-first (dut) and 4-lane LSB-first (dut4).
module tb_spi_rx_stream;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;

    logic        sclk = 1'b0, svalid = 1'b0, fifo_ready = 1'b0;
    logic [0:0]  sdata = '0;
    logic [31:0] fifo_data;
    logic        fifo_valid, frame_err;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    logic        sclk4 = 1'b0, svalid4 = 1'b0, fifo_ready4 = 1'b0;
    logic [3:0]  sdata4 = '0;
    logic [31:0] fifo_data4;
    logic        fifo_valid4, frame_err4;
    logic [2:0]  fifo_level4;
    logic [7:0]  drop_count4;

    int errors = 0;
    int checks = 0;
    int pops = 0;
    int ferr_cnt = 0;
    int drop_m = 0;
    logic [31:0] exp_q[$];

    always #5 aclk = ~aclk;

    spi_rx_stream #(
        .PACKET_LENGTH(32), .LANES(1), .FIFO_DEPTH(4), .MSB_FIRST(1), .SYNC_STAGES(2)
    ) dut (
        .aclk(aclk), .areset(areset), .sclk(sclk), .sdata(sdata), .svalid(svalid),
        .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .fifo_level(fifo_level), .frame_err(frame_err), .drop_count(drop_count)
    );

    spi_rx_stream #(
        .PACKET_LENGTH(32), .LANES(4), .FIFO_DEPTH(4), .MSB_FIRST(0), .SYNC_STAGES(2)
    ) dut4 (
        .aclk(aclk), .areset(areset), .sclk(sclk4), .sdata(sdata4), .svalid(svalid4),
        .fifo_data(fifo_data4), .fifo_valid(fifo_valid4), .fifo_ready(fifo_ready4),
        .fifo_level(fifo_level4), .frame_err(frame_err4), .drop_count(drop_count4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Consumer monitor for the single-lane instance, sampled mid-cycle.
    always @(negedge aclk) begin
        if (frame_err) ferr_cnt++;
        if (!areset && fifo_valid && fifo_ready) begin
            pops++;
            if (exp_q.size() == 0) check_eq("pop_unexpected", 32'd1, 32'd0);
            else                   check_eq("pop_data", fifo_data, exp_q.pop_front());
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // One serial beat at aclk/8; optionally pulse fifo_ready so it lands on the push cycle.
    task automatic beat(input int sel, input logic [3:0] v, input bit hit);
        if (sel == 0) begin sdata = v[0]; sclk = 1'b0; end
        else          begin sdata4 = v;   sclk4 = 1'b0; end
        tick(4);
        if (sel == 0) sclk = 1'b1; else sclk4 = 1'b1;
        if (hit) begin
            tick(3);
            fifo_ready = 1'b1;
            tick(1);
            fifo_ready = 1'b0;
        end else begin
            tick(4);
        end
    endtask

    // Reference FIFO occupancy rule: accept when fewer than DEPTH words wait, else drop.
    task automatic model_push(input logic [31:0] w);
        if (exp_q.size() >= 4) begin
            if (drop_m < 255) drop_m++;
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic end_frame1();
        sclk = 1'b0;
        tick(2);
        svalid = 1'b0;
        tick(6);
    endtask

    // mode 0: normal model push; mode 1: word accepted at full thanks to a same-cycle pop.
    task automatic send1(input logic [31:0] w, input bit keep, input int mode);
        svalid = 1'b1;
        tick(2);
        for (int i = 31; i >= 0; i--) begin
            if (i == 0) begin
                if (mode == 1) exp_q.push_back(w);
                else           model_push(w);
            end
            beat(0, {3'b000, w[i]}, (mode == 1) && (i == 0));
        end
        if (!keep) end_frame1();
    endtask

    task automatic wait_valid(input int sel);
        int n;
        n = 0;
        while (((sel == 0) ? fifo_valid : fifo_valid4) !== 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        if (n >= 300) check_eq("timeout_valid", 32'd0, 32'd1);
    endtask

    initial begin
        int p0, f0;
        logic [31:0] w, exp4;
        logic [3:0]  nib;

        // Reset state
        tick(3);
        check_eq("rst_valid", {31'd0, fifo_valid}, 32'd0);
        check_eq("rst_data", fifo_data, 32'd0);
        check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_drop", {24'd0, drop_count}, 32'd0);
        check_eq("rst_valid4", {31'd0, fifo_valid4}, 32'd0);
        areset = 1'b0;
        tick(2);

        // Single word, held then popped
        p0 = pops;
        send1(32'hA5C30F81, 1'b0, 0);
        wait_valid(0);
        check_eq("t1_level1", {29'd0, fifo_level}, 32'd1);
        check_eq("t1_head", fifo_data, 32'hA5C30F81);
        fifo_ready = 1'b1;
        tick(1);
        fifo_ready = 1'b0;
        tick(1);
        check_eq("t1_level0", {29'd0, fifo_level}, 32'd0);
        check_eq("t1_pops", pops - p0, 32'd1);

        // Random words with the consumer always ready
        fifo_ready = 1'b1;
        p0 = pops;
        repeat (3) send1($urandom, 1'b0, 0);
        tick(4);
        check_eq("rand_pops", pops - p0, 32'd3);

        // Back-to-back with svalid held high
        p0 = pops;
        f0 = ferr_cnt;
        send1(32'h11111111, 1'b1, 0);
        send1(32'h22222222, 1'b0, 0);
        tick(4);
        check_eq("b2b_pops", pops - p0, 32'd2);
        check_eq("b2b_ferr", ferr_cnt - f0, 32'd0);

        // Short frame of 13 bits, then a good word
        p0 = pops;
        f0 = ferr_cnt;
        svalid = 1'b1;
        tick(2);
        repeat (13) beat(0, 4'($urandom_range(0, 1)), 1'b0);
        end_frame1();
        check_eq("short_ferr", ferr_cnt - f0, 32'd1);
        check_eq("short_level", {29'd0, fifo_level}, 32'd0);
        check_eq("short_pops", pops - p0, 32'd0);
        send1(32'hDEADBEEF, 1'b0, 0);
        tick(4);
        check_eq("after_short_pops", pops - p0, 32'd1);

        // Backpressure: 6 words into a 4-deep FIFO
        fifo_ready = 1'b0;
        repeat (6) send1($urandom, 1'b0, 0);
        tick(2);
        check_eq("bp_level", {29'd0, fifo_level}, 32'd4);
        check_eq("bp_drop", {24'd0, drop_count}, drop_m);
        check_eq("bp_head_hold", fifo_data, exp_q[0]);
        // 7th word completes exactly when a single pop happens
        send1($urandom, 1'b0, 1);
        tick(2);
        check_eq("full_pp_level", {29'd0, fifo_level}, 32'd4);
        check_eq("full_pp_drop", {24'd0, drop_count}, drop_m);
        fifo_ready = 1'b1;
        tick(10);
        check_eq("drain_level", {29'd0, fifo_level}, 32'd0);
        check_eq("drain_model", exp_q.size(), 32'd0);

        // Reset mid-frame after 20 bits
        fifo_ready = 1'b0;
        f0 = ferr_cnt;
        svalid = 1'b1;
        tick(2);
        repeat (20) beat(0, 4'($urandom_range(0, 1)), 1'b0);
        areset = 1'b1;
        sclk = 1'b0;
        svalid = 1'b0;
        tick(2);
        check_eq("mrst_valid", {31'd0, fifo_valid}, 32'd0);
        check_eq("mrst_data", fifo_data, 32'd0);
        check_eq("mrst_level", {29'd0, fifo_level}, 32'd0);
        check_eq("mrst_drop", {24'd0, drop_count}, 32'd0);
        exp_q.delete();
        drop_m = 0;
        areset = 1'b0;
        tick(2);
        fifo_ready = 1'b1;
        p0 = pops;
        send1(32'h0000FFFF, 1'b0, 0);
        tick(4);
        check_eq("mrst_pops", pops - p0, 32'd1);
        check_eq("mrst_ferr", ferr_cnt - f0, 32'd0);

        // 4 lanes, LSB-first: nibbles 1..8 then random nibble streams
        for (int k = 0; k < 4; k++) begin
            fifo_ready4 = 1'b0;
            svalid4 = 1'b1;
            tick(2);
            exp4 = '0;
            for (int i = 0; i < 8; i++) begin
                nib = (k == 0) ? 4'(i + 1) : 4'($urandom_range(0, 15));
                beat(1, nib, 1'b0);
                exp4 = exp4 | (32'(nib) << (4 * i));
            end
            sclk4 = 1'b0;
            tick(2);
            svalid4 = 1'b0;
            tick(4);
            wait_valid(1);
            check_eq("l4_data", fifo_data4, exp4);
            check_eq("l4_level1", {29'd0, fifo_level4}, 32'd1);
            fifo_ready4 = 1'b1;
            tick(1);
            fifo_ready4 = 1'b0;
            tick(1);
            check_eq("l4_level0", {29'd0, fifo_level4}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_rx_stream.md
Name: spi_rx_stream

Overview:
- Parametrised successor to the single-lane serial receiver: deserialises a serial stream of 1..N data lanes into PACKET_LENGTH-bit words and buffers them in an internal FIFO.
- Words are presented on a valid/ready stream interface.
- Fully synchronous to aclk: sclk, svalid and sdata are oversampled and edge-detected, not used as clocks.
- Adds lane count, bit-order mode, abort detection on short frames, overflow counting and output buffering.

Parameters:
- PACKET_LENGTH, 32, word width in bits; must be a multiple of LANES.
- LANES, 1, serial data lanes sampled per sclk edge (1, 2, 4 or 8).
- FIFO_DEPTH, 4, output word buffer depth; power of two, 2 or more.
- MSB_FIRST, 1, 1 = first beat lands in the MSBs; 0 = first beat lands in the LSBs.
- SYNC_STAGES, 2, synchroniser flops on sclk, svalid and sdata (2 or more).

Ports:
- aclk, in, 1, system clock.
- areset, in, 1, synchronous active-high reset.
- sclk, in, 1, serial bit clock, asynchronous; max frequency aclk/4.
- sdata, in, LANES, serial data, sampled on the sclk rising edge.
- svalid, in, 1, frame enable; high for the whole frame.
- fifo_data, out, PACKET_LENGTH, output word.
- fifo_valid, out, 1, fifo_data is valid.
- fifo_ready, in, 1, consumer accepts the word.
- fifo_level, out, $clog2(FIFO_DEPTH)+1, words currently buffered.
- frame_err, out, 1, one-cycle pulse when a partial word is discarded.
- drop_count, out, 8, saturating count of words lost to a full FIFO.

Behaviour:
- Reset (synchronous, areset=1 at a rising aclk edge) clears all state:
  - fifo_valid=0, fifo_data=0, fifo_level=0, frame_err=0, drop_count=0.
  - Shift register and bit counter are 0; FSM goes to IDLE.
  - Reset mid-frame discards the partial word with no frame_err.
- Input sync:
  - sclk, svalid and sdata each pass through SYNC_STAGES flops.
  - Edge detect (sclk_s & ~sclk_s_d) produces a one-cycle beat strobe.
  - Input-to-beat latency is SYNC_STAGES+1 aclk cycles.
- FSM states:
  - IDLE: waits for synced svalid=1, then goes to RECV with count=0.
  - RECV: on a beat with svalid=1, shifts LANES bits in and adds LANES to count.
    - When count reaches PACKET_LENGTH, the word is complete: go to PUSH.
    - If svalid falls with count≠0, go to ABORT.
    - If svalid falls with count=0, go to IDLE.
  - PUSH: one cycle. Writes the word to the FIFO, or increments drop_count if the FIFO is full.
    - Clears count.
    - Returns to RECV if svalid=1, else IDLE.
    - A beat arriving in PUSH cannot be lost, because sclk is at most aclk/4.
  - ABORT: one cycle. Pulses frame_err, clears count, goes to IDLE.
- Shift rules:
  - MSB_FIRST=1: word ← {word[PL-LANES-1:0], sdata}.
  - MSB_FIRST=0: word ← {sdata, word[PL-1:LANES]}.
  - Within a beat, sdata[LANES-1] is the more significant bit.
- FIFO:
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Full when the pointer MSBs differ and the rest match.
  - A push and a pop in the same cycle are both allowed, including when full.
  - fifo_valid = level≠0.
  - fifo_data comes from the head entry and is stable while fifo_valid=1 and fifo_ready=0.
  - Pop occurs when fifo_valid & fifo_ready.
  - Latency from PUSH to fifo_valid is 1 cycle.
- drop_count saturates at 255 and clears only on reset.
- svalid may stay high across consecutive words; framing restarts at every word boundary.

Decomposition:
- Package spi_rx_pkg holds:
  - FSM state enum (IDLE, RECV, PUSH, ABORT).
  - A function for the level width.
  - DROP_CNT_W=8.
- Natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push/pop/full/empty/level).
- The synchroniser stays inline.

Test Plan:
- Single-lane word, MSB_FIRST=1, sdata stream 0xA5C3_0F81 MSB first, sclk=aclk/8 → one fifo_valid with fifo_data=32'hA5C30F81, level 1→0 on ready.
- LANES=4, MSB_FIRST=0, 8 beats of nibbles 1,2,…,8 → fifo_data=32'h87654321.
- Back-to-back words with svalid held high, 2 words (0x11111111, 0x22222222), fifo_ready=1 → two pops in order, no frame_err.
- Short frame: svalid drops after 13 bits → frame_err pulses once, nothing pushed; the next full word 0xDEADBEEF is received correctly.
- Backpressure with fifo_ready=0, FIFO_DEPTH=4, 6 words sent → level=4, drop_count=2; the first 4 words pop in order once ready=1. Simultaneous push+pop at full keeps level=4.
- Reset mid-frame after 20 bits, released → all outputs 0; the following word 0x0000FFFF is received exactly, with no stale bits.
